// File: rtl/board_pkg.sv
// Shared constants and types for the checkers board renderer.
package board_pkg;

   // Pixel colours, {R,G,B}
   localparam logic [23:0] C_CURSOR = 24'hFFD700;
   localparam logic [23:0] C_GRID   = 24'h404040;
   localparam logic [23:0] C_LIGHT  = 24'hFFFFFF;
   localparam logic [23:0] C_DARK   = 24'h000000;
   localparam logic [23:0] C_P1     = 24'h98F5F9;
   localparam logic [23:0] C_P2     = 24'hFE5C5E;
   localparam logic [23:0] C_K1     = 24'h3F97FC;
   localparam logic [23:0] C_K2     = 24'hD80305;
   localparam logic [23:0] C_OTHER  = 24'h123123;

   // Square status codes
   localparam logic [2:0] ST_EMPTY = 3'b000;
   localparam logic [2:0] ST_P1    = 3'b001;
   localparam logic [2:0] ST_P2    = 3'b010;
   localparam logic [2:0] ST_K1    = 3'b101;
   localparam logic [2:0] ST_K2    = 3'b110;
   localparam logic [2:0] ST_BLACK = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAW,
      S_DONE
   } state_t;

endpackage

// File: rtl/board_palette.sv
// Maps a square status code to its piece-marker colour.
module board_palette
   import board_pkg::*;
#(
   parameter int ST_W = 3
) (
   input  logic [ST_W-1:0] status,
   output logic [23:0]     colour
);

   // Piece colours; codes without a dedicated colour fall back to C_OTHER
   always_comb begin
      colour = C_OTHER;
      if (status == ST_W'(ST_P1)) colour = C_P1;
      if (status == ST_W'(ST_P2)) colour = C_P2;
      if (status == ST_W'(ST_K1)) colour = C_K1;
      if (status == ST_W'(ST_K2)) colour = C_K2;
   end

endmodule

// File: rtl/board_renderer.sv
// Full-frame checkers board renderer: streams every pixel of the board
// into the frame-buffer write port with ready/valid back-pressure.
// Pixel address and colour are computed from the next counter values so
// that both leave the module straight from registers.
module board_renderer
   import board_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int CELL    = 15,
   parameter int ST_W    = 3,
   parameter int FB_W    = 160,
   parameter int ADDR_W  = 15,
   parameter int MARK_LO = 5,
   parameter int MARK_HI = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ROWS*COLS*ST_W-1:0] Board,
   input  logic                      cursor_en,
   input  logic [$clog2(ROWS)-1:0]   cursor_row,
   input  logic [$clog2(COLS)-1:0]   cursor_col,
   output logic [ADDR_W-1:0]         the_vga_draw_frame_write_mem_address,
   output logic [23:0]               the_vga_draw_frame_write_mem_data,
   output logic                      the_vga_draw_frame_write_a_pixel,
   input  logic                      wr_ready,
   output logic                      busy,
   output logic                      done
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(CELL);
   localparam int BW = ROWS * COLS * ST_W;

   localparam logic [ADDR_W-1:0] STEP_LINE = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] STEP_SQ   = ADDR_W'(CELL);
   localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(CELL * FB_W);
   localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
   localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
   localparam logic [PW-1:0]     P_LAST    = PW'(CELL - 1);
   localparam logic [PW-1:0]     P_MLO     = PW'(MARK_LO);
   localparam logic [PW-1:0]     P_MHI     = PW'(MARK_HI);

   state_t            state;
   logic [RW-1:0]     row, n_row;
   logic [CW-1:0]     col, n_col;
   logic [PW-1:0]     py, n_py, px, n_px;
   // row_base: address of the top line of the current square row
   // line_base: address of the current pixel line; sq_base: x offset of the square
   logic [ADDR_W-1:0] row_base, n_row_base, line_base, n_line_base, sq_base, n_sq_base;
   logic [BW-1:0]     snap_board, n_board;
   logic              snap_cen, n_cen;
   logic [RW-1:0]     snap_crow, n_crow;
   logic [CW-1:0]     snap_ccol, n_ccol;

   logic              handshake, last_pixel, load;
   logic [ADDR_W-1:0] n_addr;
   logic [ST_W-1:0]   cells [ROWS][COLS];
   logic [ST_W-1:0]   status;
   logic [23:0]       pal_colour, colour;
   logic              on_rim, in_mark;

   assign handshake  = the_vga_draw_frame_write_a_pixel & wr_ready;
   assign last_pixel = (row == ROW_LAST) && (col == COL_LAST) && (py == P_LAST) && (px == P_LAST);

   // Next counters, bases and snapshot: cleared/latched on start, advanced on handshake
   always_comb begin
      n_row       = row;
      n_col       = col;
      n_py        = py;
      n_px        = px;
      n_row_base  = row_base;
      n_line_base = line_base;
      n_sq_base   = sq_base;
      n_board     = snap_board;
      n_cen       = snap_cen;
      n_crow      = snap_crow;
      n_ccol      = snap_ccol;
      load        = 1'b0;
      if (state == S_IDLE && start) begin
         n_row       = '0;
         n_col       = '0;
         n_py        = '0;
         n_px        = '0;
         n_row_base  = '0;
         n_line_base = '0;
         n_sq_base   = '0;
         n_board     = Board;
         n_cen       = cursor_en;
         n_crow      = cursor_row;
         n_ccol      = cursor_col;
         load        = 1'b1;
      end else if (state == S_DRAW && handshake && !last_pixel) begin
         load = 1'b1;
         if (px != P_LAST) begin
            n_px = px + 1'b1;
         end else begin
            n_px = '0;
            if (py != P_LAST) begin
               n_py        = py + 1'b1;
               n_line_base = line_base + STEP_LINE;
            end else begin
               n_py = '0;
               if (col != COL_LAST) begin
                  n_col       = col + 1'b1;
                  n_sq_base   = sq_base + STEP_SQ;
                  n_line_base = row_base;
               end else begin
                  n_col       = '0;
                  n_sq_base   = '0;
                  n_row       = row + 1'b1;
                  n_row_base  = row_base + STEP_ROW;
                  n_line_base = row_base + STEP_ROW;
               end
            end
         end
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         assign cells[r][c] = n_board[(r*COLS + c)*ST_W +: ST_W];
      end
   end

   assign status = cells[n_row][n_col];
   assign n_addr = n_line_base + n_sq_base + ADDR_W'(n_px);

   board_palette #(.ST_W(ST_W)) u_palette (
      .status (status),
      .colour (pal_colour)
   );

   // Colour of the next pixel; later assignments take priority
   always_comb begin
      on_rim  = (n_px == '0) || (n_py == '0) || (n_px == P_LAST) || (n_py == P_LAST);
      in_mark = (n_px >= P_MLO) && (n_px <= P_MHI) && (n_py >= P_MLO) && (n_py <= P_MHI);
      colour  = (n_row[0] ^ n_col[0]) ? C_DARK : C_LIGHT;
      if (in_mark && status != ST_W'(ST_EMPTY) && status != ST_W'(ST_BLACK))
         colour = pal_colour;
      if (n_px == '0 || n_py == '0)
         colour = C_GRID;
      if (n_cen && n_crow == n_row && n_ccol == n_col && on_rim)
         colour = C_CURSOR;
   end

   // Control FSM, counters, snapshot and registered write-port outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         row        <= '0;
         col        <= '0;
         py         <= '0;
         px         <= '0;
         row_base   <= '0;
         line_base  <= '0;
         sq_base    <= '0;
         snap_board <= '0;
         snap_cen   <= 1'b0;
         snap_crow  <= '0;
         snap_ccol  <= '0;
         the_vga_draw_frame_write_mem_address <= '0;
         the_vga_draw_frame_write_mem_data    <= '0;
         the_vga_draw_frame_write_a_pixel     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         row        <= n_row;
         col        <= n_col;
         py         <= n_py;
         px         <= n_px;
         row_base   <= n_row_base;
         line_base  <= n_line_base;
         sq_base    <= n_sq_base;
         snap_board <= n_board;
         snap_cen   <= n_cen;
         snap_crow  <= n_crow;
         snap_ccol  <= n_ccol;
         if (load) begin
            the_vga_draw_frame_write_mem_address <= n_addr;
            the_vga_draw_frame_write_mem_data    <= colour;
         end
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= S_DRAW;
                  the_vga_draw_frame_write_a_pixel <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            S_DRAW: begin
               if (handshake && last_pixel) begin
                  state <= S_DONE;
                  the_vga_draw_frame_write_a_pixel <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: scoreboard of every pixel per
// frame, a table of hand-derived pixel colours, and hand sequences for
// done/start timing and mid-draw reset.
`timescale 1ns/1ps
module tb_board_renderer;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int CELL = 15;
   localparam int FB_W = 160;
   localparam int NPIX = ROWS * COLS * CELL * CELL;
   localparam int FBSZ = FB_W * ROWS * CELL;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [191:0] Board = '0;
   logic         cursor_en = 1'b0;
   logic [2:0]   cursor_row = '0;
   logic [2:0]   cursor_col = '0;
   logic         wr_ready = 1'b0;
   logic [14:0]  addr;
   logic [23:0]  data;
   logic         a_pixel, busy, done;

   always #5 clk = ~clk;

   board_renderer dut (
      .clk                                  (clk),
      .rst                                  (rst),
      .start                                (start),
      .Board                                (Board),
      .cursor_en                            (cursor_en),
      .cursor_row                           (cursor_row),
      .cursor_col                           (cursor_col),
      .the_vga_draw_frame_write_mem_address (addr),
      .the_vga_draw_frame_write_mem_data    (data),
      .the_vga_draw_frame_write_a_pixel     (a_pixel),
      .wr_ready                             (wr_ready),
      .busy                                 (busy),
      .done                                 (done)
   );

   typedef struct {
      int          addr;
      logic [23:0] data;
   } pix_t;

   typedef struct {
      int          frame;
      int          x;
      int          y;
      logic [23:0] exp;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];
   pix_t exp_q [$];
   int   capt [FBSZ];

   int checks = 0;
   int errors = 0;
   int hs_cnt, first_addr, last_addr, done_cyc, done_cnt, stream_err, stall_err;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference colour of one pixel, straight from the colour rules
   function automatic logic [23:0] model(input logic [191:0] b, input bit cen, input int cr,
                                         input int cc, input int r, input int c,
                                         input int py, input int px);
      logic [191:0] sh;
      int st;
      bit rim;
      sh  = b >> ((r*COLS + c) * 3);
      st  = int'(sh[2:0]);
      rim = (px == 0) || (py == 0) || (px == CELL-1) || (py == CELL-1);
      if (cen && cr == r && cc == c && rim) return 24'hFFD700;
      if (px == 0 || py == 0) return 24'h404040;
      if (px >= 5 && px <= 9 && py >= 5 && py <= 9 && st != 0 && st != 7) begin
         case (st)
            1:       return 24'h98F5F9;
            2:       return 24'hFE5C5E;
            5:       return 24'h3F97FC;
            6:       return 24'hD80305;
            default: return 24'h123123;
         endcase
      end
      return ((r + c) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
   endfunction

   task automatic push_expected();
      exp_q.delete();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int py = 0; py < CELL; py++)
               for (int px = 0; px < CELL; px++)
                  exp_q.push_back('{addr: (r*CELL + py)*FB_W + c*CELL + px,
                                    data: model(Board, cursor_en, int'(cursor_row),
                                                int'(cursor_col), r, c, py, px)});
   endtask

   // Runs one frame from a start pulse until done (or a cycle budget)
   task automatic run_frame(input bit rnd, input bit disturb, input bit poke_done);
      int          cyc = 0;
      bit          fin = 1'b0;
      bit          prev_stall = 1'b0;
      logic [14:0] pa = '0;
      logic [23:0] pd = '0;
      pix_t        e;
      hs_cnt = 0; stream_err = 0; stall_err = 0; done_cnt = 0; done_cyc = 0;
      first_addr = -1; last_addr = -1;
      foreach (capt[i]) capt[i] = -1;
      push_expected();
      start = 1'b1;
      while (!fin && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == 1) check("busy_after_start", busy, 1);
         if (prev_stall && (addr !== pa || data !== pd)) stall_err++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            fin = 1'b1;
         end
         if (disturb && (cyc == 100 || cyc == 7000)) start = 1'b1;
         if (disturb && cyc == 3000) Board = {64{3'b001}};
         wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (a_pixel && wr_ready) begin
            hs_cnt++;
            if (hs_cnt == 1) first_addr = int'(addr);
            last_addr = int'(addr);
            if (int'(addr) < FBSZ) capt[int'(addr)] = int'(data);
            if (exp_q.size() == 0) stream_err++;
            else begin
               e = exp_q.pop_front();
               if (int'(addr) != e.addr || data !== e.data) stream_err++;
            end
         end
         prev_stall = a_pixel && !wr_ready;
         pa = addr;
         pd = data;
      end
      check("done_seen", fin, 1);
      check("handshakes", hs_cnt, NPIX);
      check("stream_mismatches", stream_err, 0);
      check("first_addr", first_addr, 0);
      check("last_addr", last_addr, 19159);
      check("queue_left", exp_q.size(), 0);
      if (rnd) check("stall_changes", stall_err, 0);
      else check("done_cycle", done_cyc, NPIX + 1);
      if (poke_done) start = 1'b1;
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      check("idle_no_pixel", a_pixel, 0);
      start = 1'b0;
   endtask

   task automatic check_table(input int f);
      for (int i = 0; i < NV; i++)
         if (vecs[i].frame == f)
            check($sformatf("f%0d_pix(%0d,%0d)", f, vecs[i].x, vecs[i].y),
                  capt[vecs[i].y*FB_W + vecs[i].x], longint'(vecs[i].exp));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_data"}, data, 0);
      check({tag, "_a_pixel"}, a_pixel, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      int cyc;
      int dseen;
      vecs[0]  = '{0,  0,  0, 24'h404040};
      vecs[1]  = '{0,  1,  1, 24'hFFFFFF};
      vecs[2]  = '{0, 16,  1, 24'h000000};
      vecs[3]  = '{0,  7,  7, 24'hFFFFFF};
      vecs[4]  = '{1,  7,  7, 24'h98F5F9};
      vecs[5]  = '{1,  1,  1, 24'hFFFFFF};
      vecs[6]  = '{1,  0,  3, 24'h404040};
      vecs[7]  = '{1, 52, 37, 24'hD80305};
      vecs[8]  = '{1, 37, 37, 24'hFFFFFF};
      vecs[9]  = '{1, 46, 31, 24'h000000};
      vecs[10] = '{1, 15, 20, 24'hFFD700};
      vecs[11] = '{1, 29, 20, 24'hFFD700};
      vecs[12] = '{1, 30, 20, 24'h404040};
      vecs[13] = '{2, 15, 20, 24'h404040};
      vecs[14] = '{2, 29, 20, 24'hFFFFFF};
      vecs[15] = '{2, 52, 37, 24'hD80305};

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // Frame 0: empty board, full rate; then start in DONE (ignored) and in IDLE (accepted)
      Board = '0;
      cursor_en = 1'b0;
      run_frame(1'b0, 1'b0, 1'b1);
      check_table(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_after_done_pixel", a_pixel, 1);
      check("start_after_done_addr", addr, 0);
      check("start_after_done_busy", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Frame 1: pieces at (0,0) and (2,3), cursor at (1,1)
      Board = '0;
      Board[2:0]   = 3'b001;
      Board[59:57] = 3'b110;
      cursor_en  = 1'b1;
      cursor_row = 3'd1;
      cursor_col = 3'd1;
      run_frame(1'b0, 1'b0, 1'b0);
      check_table(1);

      // Frame 2: cursor off, random back-pressure, start pulses and Board change mid-draw
      cursor_en = 1'b0;
      run_frame(1'b1, 1'b1, 1'b0);
      check_table(2);

      // Reset around pixel 5000 aborts the draw
      Board = '0;
      Board[2:0] = 3'b001;
      hs_cnt = 0;
      cyc = 0;
      start = 1'b1;
      wr_ready = 1'b1;
      while (hs_cnt < 5000 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (a_pixel && wr_ready) hs_cnt++;
      end
      check("reached_pixel_5000", hs_cnt, 5000);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst = 1'b1;
      dseen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done || a_pixel) dseen++;
      end
      check("no_done_after_abort", dseen, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart_addr", addr, 0);
      check("restart_pixel", a_pixel, 1);
      check("restart_data", data, 24'h404040);
      @(negedge clk);
      check("restart_addr_next", addr, 1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      wr_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_renderer.md
# board_renderer

Parametrised full-frame board renderer for the checkers VGA path. On a `start` pulse it snapshots the packed board state and streams every pixel of a `ROWS`×`COLS` grid of `CELL`×`CELL` squares into the frame-buffer write port. Each square is drawn with a grid line, a light/dark checker background, a centred piece marker and an optional cursor highlight. It sits between the game-logic board register and the VGA frame-buffer write interface, and it adds back-pressure and completion signalling to that interface.

## Interface
- `ROWS`, 8, board rows
- `COLS`, 8, board columns
- `CELL`, 15, square edge in pixels (≥ 4)
- `ST_W`, 3, status bits per square
- `FB_W`, 160, frame-buffer line pitch in pixels
- `ADDR_W`, 15, frame-buffer address width
- `MARK_LO`, 5, first in-cell pixel offset of the piece marker (both axes)
- `MARK_HI`, 9, last in-cell pixel offset of the piece marker (inclusive)

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle request to redraw the board
- `Board`  in  ROWS*COLS*ST_W  packed status; square `r*COLS+c` occupies bits `[(r*COLS+c)*ST_W +: ST_W]`
- `cursor_en`  in  1  enable the cursor highlight
- `cursor_row`  in  $clog2(ROWS)  cursor square row
- `cursor_col`  in  $clog2(COLS)  cursor square column
- `the_vga_draw_frame_write_mem_address`  out  ADDR_W  pixel address, `y*FB_W + x`
- `the_vga_draw_frame_write_mem_data`  out  24  pixel colour, `{R,G,B}`
- `the_vga_draw_frame_write_a_pixel`  out  1  write valid
- `wr_ready`  in  1  frame buffer accepts the write this cycle
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, DRAW, DONE.
- IDLE → DRAW when `start`=1.
  - Latch `Board`, `cursor_en`, `cursor_row` and `cursor_col` into snapshot registers.
  - Clear the counters `row`, `col`, `py`, `px`.
- DRAW presents one pixel with `a_pixel`=1.
  - Counters advance only on a handshake (`a_pixel & wr_ready`).
  - Order: `px` increments fastest, then `py`, then `col`, then `row`. Raster order within a square, squares in row-major order.
- DRAW → DONE on the handshake of the pixel at (`row`=ROWS-1, `col`=COLS-1, `py`=`px`=CELL-1).
- DONE: `done`=1 and `a_pixel`=0 for one cycle, then return to IDLE.
- `start` while not in IDLE is ignored. No queuing.
- Address: `x = col*CELL + px`, `y = row*CELL + py`, `addr = y*FB_W + x`.
  - Keep running bases, with no multipliers or dividers: the line base adds `FB_W` per `py` step, and the square base adds `CELL` per `col` step.
  - Truncate to `ADDR_W`. Out-of-frame sizing is a parameter error.
- Colour priority, highest first:
  1. Cursor: `px` or `py` is 0 or CELL-1, and the snapshot cursor is enabled and matches (`row`,`col`) → `C_CURSOR` 24'hFFD700.
  2. Grid: `px`==0 or `py`==0 → `C_GRID` 24'h404040.
  3. Marker: `MARK_LO` ≤ `px`,`py` ≤ `MARK_HI`, and status is not 000 or 111 → palette(status).
  4. Background: `C_LIGHT` 24'hFFFFFF when (`row`+`col`) is even, else `C_DARK` 24'h000000.
- Palette:
  - 001 → 24'h98F5F9
  - 010 → 24'hFE5C5E
  - 101 → 24'h3F97FC
  - 110 → 24'hD80305
  - other codes → 24'h123123

## Timing
- Every output and state register is registered.
- Reset (`rst`=0 at a `clk` edge): state IDLE, address 0, data 0, `a_pixel` 0, `busy` 0, `done` 0, all counters 0.
- Reset mid-draw aborts the draw immediately. No `done` is issued.
- The first pixel is valid in the cycle after the `start` sample.
- Address and data are held stable while `a_pixel`=1 and `wr_ready`=0.
- With `wr_ready` held high, one pixel per cycle: `done` asserts exactly ROWS*COLS*CELL² + 1 cycles after the start edge (14401 at defaults).
- `Board` changes during DRAW have no effect, because the snapshot is used.
- `start` in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.

## Structure
- Package `board_pkg`:
  - colour constants `C_*`
  - status code constants (`ST_EMPTY`=000, `ST_P1`, `ST_P2`, `ST_K1`, `ST_K2`, `ST_BLACK`=111)
  - state enum
- Sub-module `board_palette`: combinational mapping from status to 24-bit colour, instantiated once.

## Test plan
- Empty board (all 000), `wr_ready`=1, `start` pulse → 14400 writes, addr(0,0)=0, last addr=119*160+119=19159, `done` at cycle 14401, `busy` low after.
- Square (0,0)=001 → pixel (7,7) addr 1127 data 98F5F9; pixel (1,1) data FFFFFF; pixel (0,3) data 404040.
- Square (2,3)=110 → pixel (52,37) data D80305; square (2,2)=000 → pixel (37,37) data FFFFFF; square (2,3) background pixel (46,31) data 000000.
- Cursor at (1,1) enabled → pixel (15,20) and (29,20) data FFD700; cursor disabled → pixel (15,20) 404040.
- `wr_ready` toggled randomly at ~50% → address/data stable during stalls, 14400 unique handshakes in order, `start` pulses mid-draw ignored, `Board` change mid-draw has no effect.
- `rst` low at pixel 5000 → next cycle all outputs 0, IDLE, no `done`; new `start` restarts at address 0.
